// File: rtl/pool_write_packer.sv
// Packs PIX_W-bit pooled pixels into LANES-wide DRAM words. A one-entry output
// register with a ready handshake feeds the DRAM write port.
module pool_write_packer #(
  parameter int PIX_W     = 8,
  parameter int LANES     = 8,
  parameter int ADDR_W    = 10,
  parameter int TOTAL_PIX = 196,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pix_valid,
  input  logic [PIX_W-1:0]         pix_data,
  output logic                     pix_ready,
  input  logic                     mem_ready,
  output logic                     DRAMwriteEn,
  output logic [ADDR_W-1:0]        DRAMwriteAddr,
  output logic [PIX_W*LANES-1:0]   DRAMwriteData,
  output logic                     busy,
  output logic                     done
);
  localparam int DATA_W = PIX_W * LANES;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW     = (TOTAL_PIX > 1) ? $clog2(TOTAL_PIX) : 1;

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [ADDR_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   pack_q, pack_d;
  logic                pack_full_q, pack_full_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic                accept, out_free, last_lane, last_pix, complete_now;
  logic [DATA_W-1:0]   word_new;

  assign pix_ready     = (state_q == PACK) && !(pack_full_q && out_valid_q && !mem_ready);
  assign accept        = pix_valid && pix_ready;
  assign out_free      = !out_valid_q || mem_ready;
  assign last_lane     = (lane_q == LW'(LANES - 1));
  assign last_pix      = (cnt_q == CW'(TOTAL_PIX - 1));
  assign complete_now  = accept && (last_lane || last_pix);

  assign DRAMwriteEn   = out_valid_q;
  assign DRAMwriteAddr = out_addr_q;
  assign DRAMwriteData = out_data_q;
  assign busy          = (state_q == PACK) || (state_q == FLUSH);
  assign done          = (state_q == DONE);

  // Lane 0 starts a fresh word, so stale lanes never leak into a padded word.
  always_comb begin
    word_new = (lane_q == '0) ? '0 : pack_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_q == LW'(i)) word_new[PIX_W*i +: PIX_W] = pix_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    word_d      = word_q;
    pack_d      = pack_q;
    pack_full_d = pack_full_q;
    out_valid_d = out_valid_q && !mem_ready;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    if (accept) begin
      pack_d = word_new;
      lane_d = last_lane ? '0 : lane_q + LW'(1);
      cnt_d  = last_pix ? cnt_q : cnt_q + CW'(1);
    end

    // A parked word has priority; otherwise a word completing now bypasses
    // the pack register straight into the output register.
    if (pack_full_q && out_free) begin
      out_valid_d = 1'b1;
      out_addr_d  = ADDR_W'(BASE_ADDR) + word_q;
      out_data_d  = pack_q;
      word_d      = word_q + ADDR_W'(1);
      pack_full_d = complete_now;
    end else if (complete_now) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_addr_d  = ADDR_W'(BASE_ADDR) + word_q;
        out_data_d  = word_new;
        word_d      = word_q + ADDR_W'(1);
      end else begin
        pack_full_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d     = PACK;
          cnt_d       = '0;
          lane_d      = '0;
          word_d      = '0;
          pack_d      = '0;
          pack_full_d = 1'b0;
        end
      end
      PACK:  if (accept && last_pix) state_d = FLUSH;
      FLUSH: if (!pack_full_q && out_free) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      pack_q      <= '0;
      pack_full_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      pack_q      <= pack_d;
      pack_full_q <= pack_full_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_pool_write_packer.sv
// Scoreboard bench: expected words are built from accepted pixels and checked
// against each DRAM write handshake, across three parameterisations.
module tb_pool_write_packer;
  localparam int PW = 8;
  localparam int LN = 8;
  localparam int AW = 10;
  localparam int DW = PW * LN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st[3], pv[3], mr[3], pr[3], we[3], bz[3], dn[3];
  logic [PW-1:0] pd[3];
  logic [AW-1:0] wa[3];
  logic [DW-1:0] wd[3];

  always #5 clk = ~clk;

  pool_write_packer #(.PIX_W(PW), .LANES(LN), .ADDR_W(AW), .TOTAL_PIX(196), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst(rst_n), .start(st[0]), .pix_valid(pv[0]), .pix_data(pd[0]),
    .pix_ready(pr[0]), .mem_ready(mr[0]), .DRAMwriteEn(we[0]), .DRAMwriteAddr(wa[0]),
    .DRAMwriteData(wd[0]), .busy(bz[0]), .done(dn[0]));
  pool_write_packer #(.PIX_W(PW), .LANES(LN), .ADDR_W(AW), .TOTAL_PIX(16), .BASE_ADDR(0)) u1 (
    .clk(clk), .rst(rst_n), .start(st[1]), .pix_valid(pv[1]), .pix_data(pd[1]),
    .pix_ready(pr[1]), .mem_ready(mr[1]), .DRAMwriteEn(we[1]), .DRAMwriteAddr(wa[1]),
    .DRAMwriteData(wd[1]), .busy(bz[1]), .done(dn[1]));
  pool_write_packer #(.PIX_W(PW), .LANES(LN), .ADDR_W(AW), .TOTAL_PIX(32), .BASE_ADDR(1022)) u2 (
    .clk(clk), .rst(rst_n), .start(st[2]), .pix_valid(pv[2]), .pix_data(pd[2]),
    .pix_ready(pr[2]), .mem_ready(mr[2]), .DRAMwriteEn(we[2]), .DRAMwriteAddr(wa[2]),
    .DRAMwriteData(wd[2]), .busy(bz[2]), .done(dn[2]));

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_frame(input int s, input int npix, input int base,
                           input int stall_word, input int stall_len, input int abort_at,
                           input int stray_at, input bit skip_start, input bit chain);
    int k, nw, got, cyc, stall_left, refused, early, ln;
    logic [DW-1:0] cur, pdat;
    logic [AW-1:0] pa;
    logic pen, pmr;
    bit fin;
    exp_t e;
    k = 0; nw = (npix + LN - 1) / LN; got = 0; cyc = 0; stall_left = 0;
    refused = 0; early = 0; cur = '0; pdat = '0; pa = '0; pen = 1'b0; pmr = 1'b1; fin = 1'b0;
    sb.delete();
    if (!skip_start) begin
      @(negedge clk);
      st[s] = 1'b1; pv[s] = 1'b0; mr[s] = 1'b1;
      #1 chk("idle_before_start", {bz[s], dn[s], we[s]}, 0);
    end
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (fin) begin
        st[s] = chain; pv[s] = 1'b0; mr[s] = 1'b1;
        #1;
        chk("done_pulse", dn[s], 1);
        chk("early_done", early, 0);
        chk("write_count", got, nw);
        chk("pixel_count", k, npix);
        chk("refused_cycles", refused, (stall_len > LN) ? stall_len - LN : 0);
        if (!chain) begin
          @(negedge clk);
          st[s] = 1'b0;
          #1 chk("idle_after_done", {bz[s], dn[s], we[s]}, 0);
        end
        return;
      end
      st[s] = (stray_at >= 0) && (k == stray_at);
      mr[s] = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      pv[s] = (k < npix);
      pd[s] = k[7:0];
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_en", we[s], 0);
        chk("rst_addr", wa[s], 0);
        chk("rst_data", wd[s], 0);
        chk("rst_ctl", {bz[s], dn[s], pr[s]}, 0);
        @(negedge clk);
        rst_n = 1'b1; pv[s] = 1'b0; st[s] = 1'b0;
        sb.delete();
        return;
      end
      #1;
      if (cyc == 1) chk("busy_in_pack", bz[s], 1);
      if (dn[s]) early++;
      if (we[s] && pen && !pmr) begin
        chk("hold_addr", wa[s], pa);
        chk("hold_data", wd[s], pdat);
      end
      if (we[s] && mr[s]) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("addr", wa[s], e.a);
          chk("data", wd[s], e.d);
          if (stall_len == 0) chk("write_latency", cyc, e.cyc + 1);
        end
        if (npix == 196 && wa[s] == 10'd0) chk("word0_const", wd[s], 64'h0706050403020100);
        if (npix == 196 && wa[s] == 10'd24) chk("word24_const", wd[s], 64'h00000000C3C2C1C0);
        got++;
        if (got == nw) fin = 1'b1;
      end
      if (pv[s] && pr[s]) begin
        ln = k % LN;
        if (ln == 0) cur = '0;
        cur[PW*ln +: PW] = pd[s];
        if (ln == LN - 1 || k == npix - 1) begin
          e.a = AW'(base + k / LN);
          e.d = cur;
          e.cyc = cyc;
          sb.push_back(e);
          if (k / LN == stall_word) stall_left = stall_len;
        end
        k++;
      end else if (pv[s] && bz[s]) begin
        refused++;
      end
      pen = we[s]; pmr = mr[s]; pa = wa[s]; pdat = wd[s];
    end
    chk("frame_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; pv[i] = 1'b0; mr[i] = 1'b1; pd[i] = '0;
    end
    @(negedge clk);
    #1;
    chk("reset_en", we[0], 0);
    chk("reset_addr", wa[0], 0);
    chk("reset_data", wd[0], 0);
    chk("reset_ctl", {bz[0], dn[0], pr[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, 196, 0, -1, 0, -1, -1, 1'b0, 1'b0);
    run_frame(0, 196, 0, 3, 6, -1, -1, 1'b0, 1'b0);
    run_frame(0, 196, 0, 3, 12, -1, -1, 1'b0, 1'b0);
    run_frame(1, 16, 0, -1, 0, -1, -1, 1'b0, 1'b0);
    run_frame(2, 32, 1022, -1, 0, -1, -1, 1'b0, 1'b0);
    run_frame(0, 196, 0, -1, 0, 50, -1, 1'b0, 1'b0);
    run_frame(0, 196, 0, -1, 0, -1, -1, 1'b0, 1'b0);
    run_frame(0, 196, 0, -1, 0, -1, 10, 1'b0, 1'b1);
    run_frame(0, 196, 0, -1, 0, -1, -1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
